// File: rtl/rr_arb_four.sv
// rr_arb_four: four-way round-robin arbiter with a bounded grant hold time.
// A grant lasts until the holder signals done, drops its request, or has
// held the resource for HOLD_MAX cycles. In the last case a one-cycle
// timeout pulse is raised. Every release is followed by at least one idle
// cycle before the next grant is issued.
module rr_arb_four #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The counter holds (cycles already granted - 1) while in GRANT, so the
    // limit is reached when it equals HOLD_MAX-1.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [1:0] gnt_idx_nxt;
    logic       gnt_valid_nxt;
    logic       timeout_nxt;

    logic [1:0] pick_idx;
    logic       holder_req;
    logic       at_limit;
    logic       release_now;

    // First set bit of r, searching p, p+1, p+2, p+3 with 2-bit wrap.
    // The loop runs from the farthest offset to the nearest so the nearest
    // requester is the last one written and therefore wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    // Release conditions as seen by the current holder.
    always_comb begin
        pick_idx    = rr_pick(req, ptr);
        holder_req  = req[gnt_idx];
        at_limit    = (cnt == HOLD_LAST);
        release_now = done || !holder_req || at_limit;
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cnt_nxt       = cnt;
        gnt_idx_nxt   = gnt_idx;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                gnt_valid_nxt = 1'b0;
                if (req != 4'b0000) begin
                    gnt_idx_nxt   = pick_idx;
                    gnt_valid_nxt = 1'b1;
                    cnt_nxt       = 8'd0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_valid_nxt = 1'b0;
                    ptr_nxt       = gnt_idx + 2'd1;
                    cnt_nxt       = 8'd0;
                    state_nxt     = IDLE;
                    // A timeout is reported only when the hold limit is the
                    // sole reason for the release.
                    timeout_nxt   = at_limit && !done && holder_req;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            cnt       <= 8'd0;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            gnt_idx   <= gnt_idx_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arb_four.sv
// tb_rr_arb_four: directed bench for rr_arb_four with HOLD_MAX=8 and a
// second instance with HOLD_MAX=1.
module tb_rr_arb_four;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    logic [3:0] req_h1;
    logic       done_h1;
    logic [1:0] gnt_idx_h1;
    logic       gnt_valid_h1;
    logic       timeout_h1;

    int n_tests;
    int n_fail;

    rr_arb_four #(.HOLD_MAX(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    rr_arb_four #(.HOLD_MAX(1)) u_dut_h1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req_h1),
        .done      (done_h1),
        .gnt_idx   (gnt_idx_h1),
        .gnt_valid (gnt_valid_h1),
        .timeout   (timeout_h1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] idx, input logic to);
        chk({tag, ".valid"}, {31'd0, gnt_valid}, {31'd0, v});
        if (v) chk({tag, ".idx"}, {30'd0, gnt_idx}, {30'd0, idx});
        chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
    endtask

    task automatic chk_h1(input string tag, input logic v, input logic to);
        chk({tag, ".valid"}, {31'd0, gnt_valid_h1}, {31'd0, v});
        if (v) chk({tag, ".idx"}, {30'd0, gnt_idx_h1}, 32'd0);
        chk({tag, ".timeout"}, {31'd0, timeout_h1}, {31'd0, to});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [6];
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        req_h1 = 4'b0000; done_h1 = 1'b0;
        tick();
        tick();
        chk("rst.valid", {31'd0, gnt_valid}, 32'd0);
        chk("rst.idx", {30'd0, gnt_idx}, 32'd0);
        chk("rst.timeout", {31'd0, timeout}, 32'd0);
        chk("rst.h1valid", {31'd0, gnt_valid_h1}, 32'd0);
        rst = 1'b0;
        tick();
        chk_out("idle", 1'b0, 2'd0, 1'b0);

        // Single requester 2, done on the third grant cycle.
        req = 4'b0100;
        tick(); chk_out("r2.c1", 1'b1, 2'd2, 1'b0);
        tick(); chk_out("r2.c2", 1'b1, 2'd2, 1'b0);
        tick(); chk_out("r2.c3", 1'b1, 2'd2, 1'b0);
        done = 1'b1;
        tick(); chk_out("r2.rel", 1'b0, 2'd2, 1'b0);
        chk("r2.idxhold", {30'd0, gnt_idx}, 32'd2);
        done = 1'b0; req = 4'b0000;
        tick(); chk_out("r2.idle", 1'b0, 2'd2, 1'b0);

        // All request, done held high: ptr=3 first, then 0,1,2,3,0.
        seq = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        req = 4'b1111; done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); chk_out($sformatf("rr%0d.gnt", i), 1'b1, seq[i], 1'b0);
            tick(); chk_out($sformatf("rr%0d.gap", i), 1'b0, seq[i], 1'b0);
        end
        req = 4'b0000; done = 1'b0;
        tick(); chk_out("rr.idle", 1'b0, 2'd0, 1'b0);

        // Requester 0 alone, never done: timeout after 8 cycles.
        req = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            tick(); chk_out($sformatf("to.c%0d", i), 1'b1, 2'd0, 1'b0);
        end
        tick(); chk_out("to.pulse", 1'b0, 2'd0, 1'b1);
        tick(); chk_out("to.regrant", 1'b1, 2'd0, 1'b0);

        // Same grant continues; done on the 8th cycle is a normal release.
        for (int i = 2; i <= 7; i++) begin
            tick(); chk_out($sformatf("d8.c%0d", i), 1'b1, 2'd0, 1'b0);
        end
        tick(); chk_out("d8.c8", 1'b1, 2'd0, 1'b0);
        done = 1'b1;
        tick(); chk_out("d8.rel", 1'b0, 2'd0, 1'b0);
        done = 1'b0; req = 4'b0000;
        tick(); chk_out("d8.idle", 1'b0, 2'd0, 1'b0);

        // Grant to 1, drop req[1] mid-grant with req[3] still pending.
        req = 4'b1010;
        tick(); chk_out("drop.c1", 1'b1, 2'd1, 1'b0);
        tick(); chk_out("drop.c2", 1'b1, 2'd1, 1'b0);
        req = 4'b1000;
        tick(); chk_out("drop.rel", 1'b0, 2'd1, 1'b0);
        tick(); chk_out("drop.g3", 1'b1, 2'd3, 1'b0);
        req = 4'b0000;
        tick(); chk_out("drop.idle", 1'b0, 2'd3, 1'b0);

        // Grant to 2, other request bits toggle without effect, reset on cycle 4.
        req = 4'b0100;
        tick(); chk_out("rg.c1", 1'b1, 2'd2, 1'b0);
        req = 4'b1111;
        tick(); chk_out("rg.c2", 1'b1, 2'd2, 1'b0);
        req = 4'b0110;
        tick(); chk_out("rg.c3", 1'b1, 2'd2, 1'b0);
        tick(); chk_out("rg.c4", 1'b1, 2'd2, 1'b0);
        rst = 1'b1;
        tick();
        chk("rg.rst.valid", {31'd0, gnt_valid}, 32'd0);
        chk("rg.rst.idx", {30'd0, gnt_idx}, 32'd0);
        chk("rg.rst.timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b0; req = 4'b1100;
        tick(); chk_out("rg.after", 1'b1, 2'd2, 1'b0);
        req = 4'b0000;
        tick(); chk_out("rg.idle", 1'b0, 2'd2, 1'b0);

        // HOLD_MAX=1 instance.
        req_h1 = 4'b0001;
        tick(); chk_h1("h1.g1", 1'b1, 1'b0);
        tick(); chk_h1("h1.to", 1'b0, 1'b1);
        tick(); chk_h1("h1.g2", 1'b1, 1'b0);
        done_h1 = 1'b1;
        tick(); chk_h1("h1.done", 1'b0, 1'b0);
        done_h1 = 1'b0;
        tick(); chk_h1("h1.g3", 1'b1, 1'b0);
        req_h1 = 4'b0000;
        tick(); chk_h1("h1.drop", 1'b0, 1'b0);
        tick(); chk_h1("h1.idle", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
